tomasulo_issue: RTL and testbench

Parametrised instruction issue stage for the Tomasulo core. It sits between the instruction queue and the reservation stations. It decodes one Alpha instruction per cycle, allocates the lowest free station of the required class, and emits a registered issue packet (tag, operand register numbers, destination). It also tracks station occupancy internally and blocks issue while a control-transfer instruction is unresolved.

---
 rtl/tomasulo_pkg.sv | 67 ++++++
 rtl/tomasulo_issue_prio_alloc.sv | 23 ++
 rtl/tomasulo_issue.sv | 195 +++++++++++++++++++
 tb/tb_tomasulo_issue.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo issue stage: opcodes, station classes,
// tag layout helpers and the decoded-instruction record.
package tomasulo_pkg;

    localparam int N_CLS = 5;
    localparam int NOTAG = 0;

    // Class order fixes both the tag layout and the iss_ctrl bit position.
    typedef enum logic [2:0] {
        CLS_ADD  = 3'd0,
        CLS_MULT = 3'd1,
        CLS_LD   = 3'd2,
        CLS_ST   = 3'd3,
        CLS_BR   = 3'd4
    } cls_e;

    localparam logic [5:0] OP_INTA = 6'h10;
    localparam logic [5:0] OP_INTL = 6'h11;
    localparam logic [5:0] OP_INTM = 6'h13;
    localparam logic [5:0] OP_JMP  = 6'h1A;
    localparam logic [5:0] OP_LDQ  = 6'h29;
    localparam logic [5:0] OP_STQ  = 6'h2D;
    localparam logic [5:0] OP_BR   = 6'h30;
    localparam logic [5:0] OP_BSR  = 6'h34;
    localparam logic [5:0] OP_BEQ  = 6'h39;
    localparam logic [5:0] OP_BNE  = 6'h3D;

    typedef struct packed {
        logic       nop;
        cls_e       cls;
        logic [4:0] src1;
        logic [4:0] src2;
        logic [4:0] dest;
        logic       src1_use;
        logic       src2_use;
        logic       nodest;
        logic [7:0] lit;
    } decode_t;

    function automatic logic [N_CLS-1:0] cls_onehot(input cls_e c);
        return N_CLS'(1) << c;
    endfunction

    function automatic int cls_count(input cls_e c, input int n_add, input int n_mult,
                                     input int n_ld, input int n_st, input int n_br);
        case (c)
            CLS_ADD:  return n_add;
            CLS_MULT: return n_mult;
            CLS_LD:   return n_ld;
            CLS_ST:   return n_st;
            default:  return n_br;
        endcase
    endfunction

    // First tag of class c; tags are 1-based so NOTAG is never handed out.
    function automatic int tag_base(input cls_e c, input int n_add, input int n_mult,
                                    input int n_ld, input int n_st);
        int b;
        b = NOTAG + 1;
        if (c > CLS_ADD)  b += n_add;
        if (c > CLS_MULT) b += n_mult;
        if (c > CLS_LD)   b += n_ld;
        if (c > CLS_ST)   b += n_st;
        return b;
    endfunction

endpackage

// File: rtl/tomasulo_issue_prio_alloc.sv
// Lowest-free-index finder over one reservation-station class.
module prio_alloc #(
    parameter int W  = 4,
    parameter int IW = 4
) (
    input  logic [W-1:0]  busy,
    output logic          found,
    output logic [IW-1:0] idx
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/tomasulo_issue.sv
// Issue stage: decodes one Alpha instruction per cycle and allocates a station.
// Optional ISSUE_LITERAL_EN turns bit 12 of operate-format ops into a literal.
module tomasulo_issue
    import tomasulo_pkg::*;
#(
    parameter int N_ADD  = 3,
    parameter int N_MULT = 2,
    parameter int N_LD   = 3,
    parameter int N_ST   = 2,
    parameter int N_BR   = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             stall,
    input  logic             rel_valid,
    input  logic [TAG_W-1:0] rel_tag,
    input  logic             br_resolve,
    input  logic             flush,
    output logic             iss_valid,
    output logic [4:0]       iss_ctrl,
    output logic [TAG_W-1:0] iss_tag,
    output logic [5:0]       iss_opcode,
    output logic [4:0]       iss_src1,
    output logic [4:0]       iss_src2,
    output logic [4:0]       iss_dest,
    output logic             iss_src1_use,
    output logic             iss_src2_use,
    output logic             iss_nodest,
    output logic [7:0]       iss_lit
);

    localparam int TOTAL = N_ADD + N_MULT + N_LD + N_ST + N_BR;

    typedef enum logic {ST_RUN, ST_BR_WAIT} state_e;

    state_e           state, state_next;
    logic [TOTAL-1:0] busy;
    decode_t          dec;
    logic [N_CLS-1:0] cls_found;
    logic [TAG_W-1:0] cls_tag [N_CLS];
    logic [TAG_W-1:0] alloc_tag;
    logic [TOTAL-1:0] set_mask, rel_mask;
    logic             class_free, transfer, do_issue, rel_hit;
    logic [5:0]       opcode;
    logic [4:0]       ra, rb, rc;
    logic             unused_instr;

    assign opcode       = in_instr[31:26];
    assign ra           = in_instr[25:21];
    assign rb           = in_instr[20:16];
    assign rc           = in_instr[4:0];
    assign unused_instr = ^in_instr[15:5];

    for (genvar c = 0; c < N_CLS; c++) begin : g_alloc
        localparam int W   = cls_count(cls_e'(c), N_ADD, N_MULT, N_LD, N_ST, N_BR);
        localparam int OFF = tag_base(cls_e'(c), N_ADD, N_MULT, N_LD, N_ST) - 1;
        logic [TAG_W-1:0] idx;
        prio_alloc #(.W(W), .IW(TAG_W)) u_alloc (
            .busy  (busy[OFF +: W]),
            .found (cls_found[c]),
            .idx   (idx)
        );
        assign cls_tag[c] = TAG_W'(OFF + 1) + idx;
    end

    always_comb begin
        dec        = '0;
        dec.nop    = 1'b1;
        dec.nodest = 1'b1;
        case (opcode)
            OP_INTA, OP_INTL, OP_INTM: begin
                dec.nop      = 1'b0;
                dec.cls      = (opcode == OP_INTM) ? CLS_MULT : CLS_ADD;
                dec.src1     = ra;
                dec.src1_use = 1'b1;
                dec.src2     = rb;
                dec.src2_use = 1'b1;
                dec.dest     = rc;
                dec.nodest   = 1'b0;
`ifdef ISSUE_LITERAL_EN
                if (in_instr[12]) begin
                    dec.src2     = '0;
                    dec.src2_use = 1'b0;
                    dec.lit      = in_instr[20:13];
                end
`endif
            end
            OP_LDQ: begin
                dec.nop      = 1'b0;
                dec.cls      = CLS_LD;
                dec.src1     = rb;
                dec.src1_use = 1'b1;
                dec.dest     = ra;
                dec.nodest   = 1'b0;
            end
            OP_STQ: begin
                dec.nop      = 1'b0;
                dec.cls      = CLS_ST;
                dec.src1     = ra;
                dec.src1_use = 1'b1;
                dec.src2     = rb;
                dec.src2_use = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.nop      = 1'b0;
                dec.cls      = CLS_BR;
                dec.src1     = ra;
                dec.src1_use = 1'b1;
            end
            OP_BR, OP_BSR: begin
                dec.nop    = 1'b0;
                dec.cls    = CLS_BR;
                dec.dest   = ra;
                dec.nodest = 1'b0;
            end
            OP_JMP: begin
                dec.nop      = 1'b0;
                dec.cls      = CLS_BR;
                dec.src1     = rb;
                dec.src1_use = 1'b1;
                dec.dest     = ra;
                dec.nodest   = 1'b0;
            end
            default: ;
        endcase
    end

    assign class_free = cls_found[dec.cls];
    assign alloc_tag  = cls_tag[dec.cls];
    assign in_ready   = (state == ST_RUN) & ~flush & (dec.nop | class_free);
    assign stall      = in_valid & ~in_ready;
    assign transfer   = in_valid & in_ready;
    assign do_issue   = transfer & ~dec.nop;

    // A release of a non-busy tag clears nothing, so clear-then-set is safe.
    assign rel_hit  = rel_valid && (rel_tag != TAG_W'(NOTAG)) && (rel_tag <= TAG_W'(TOTAL));
    assign rel_mask = rel_hit  ? (TOTAL'(1) << (rel_tag - TAG_W'(1)))   : '0;
    assign set_mask = do_issue ? (TOTAL'(1) << (alloc_tag - TAG_W'(1))) : '0;

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:     if (do_issue && dec.cls == CLS_BR) state_next = ST_BR_WAIT;
            ST_BR_WAIT: if (br_resolve) state_next = ST_RUN;
            default:    state_next = ST_RUN;
        endcase
        if (flush) state_next = ST_RUN;
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            busy  <= '0;
        end else begin
            state <= state_next;
            busy  <= flush ? '0 : ((busy & ~rel_mask) | set_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid    <= 1'b0;
            iss_ctrl     <= '0;
            iss_tag      <= '0;
            iss_opcode   <= '0;
            iss_src1     <= '0;
            iss_src2     <= '0;
            iss_dest     <= '0;
            iss_src1_use <= 1'b0;
            iss_src2_use <= 1'b0;
            iss_nodest   <= 1'b1;
            iss_lit      <= '0;
        end else begin
            iss_valid <= do_issue;
            if (do_issue) begin
                iss_ctrl     <= cls_onehot(dec.cls);
                iss_tag      <= alloc_tag;
                iss_opcode   <= opcode;
                iss_src1     <= dec.src1;
                iss_src2     <= dec.src2;
                iss_dest     <= dec.dest;
                iss_src1_use <= dec.src1_use;
                iss_src2_use <= dec.src2_use;
                iss_nodest   <= dec.nodest;
                iss_lit      <= dec.lit;
            end
        end
    end

endmodule

// File: tb/tb_tomasulo_issue.sv
// Scoreboard bench for tomasulo_issue: directed scenarios plus random traffic
// checked against a tag-array reference model.
module tb_tomasulo_issue;

    localparam int N_ADD = 3, N_MULT = 2, N_LD = 3, N_ST = 2, N_BR = 1, TAG_W = 4;
    localparam int TOTAL = N_ADD + N_MULT + N_LD + N_ST + N_BR;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_instr = '0;
    logic             in_ready, stall;
    logic             rel_valid = 1'b0;
    logic [TAG_W-1:0] rel_tag = '0;
    logic             br_resolve = 1'b0;
    logic             flush = 1'b0;
    logic             iss_valid;
    logic [4:0]       iss_ctrl;
    logic [TAG_W-1:0] iss_tag;
    logic [5:0]       iss_opcode;
    logic [4:0]       iss_src1, iss_src2, iss_dest;
    logic             iss_src1_use, iss_src2_use, iss_nodest;
    logic [7:0]       iss_lit;

    tomasulo_issue #(.N_ADD(N_ADD), .N_MULT(N_MULT), .N_LD(N_LD), .N_ST(N_ST),
                     .N_BR(N_BR), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .stall(stall), .rel_valid(rel_valid), .rel_tag(rel_tag),
        .br_resolve(br_resolve), .flush(flush), .iss_valid(iss_valid),
        .iss_ctrl(iss_ctrl), .iss_tag(iss_tag), .iss_opcode(iss_opcode),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_dest(iss_dest),
        .iss_src1_use(iss_src1_use), .iss_src2_use(iss_src2_use),
        .iss_nodest(iss_nodest), .iss_lit(iss_lit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         nop;
        int         cls;
        logic [4:0] ctrl;
        logic [3:0] tag;
        logic [5:0] op;
        logic [4:0] s1, s2, d;
        bit         u1, u2, nd;
        logic [7:0] lit;
    } pkt_t;

    pkt_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mbusy [16];
    bit   mwait;
    int   cnt [5];
    int   lo  [5];
    logic last_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written straight from the opcode table.
    function automatic pkt_t model_decode(input logic [31:0] ins);
        pkt_t p;
        logic [4:0] ra, rb, rc;
        p = '{default: '0};
        p.nop = 1; p.nd = 1; p.op = ins[31:26];
        ra = ins[25:21]; rb = ins[20:16]; rc = ins[4:0];
        case (p.op)
            6'h10, 6'h11, 6'h13: begin
                p.nop = 0; p.cls = (p.op == 6'h13) ? 1 : 0;
                p.s1 = ra; p.u1 = 1; p.s2 = rb; p.u2 = 1; p.d = rc; p.nd = 0;
`ifdef ISSUE_LITERAL_EN
                if (ins[12]) begin p.s2 = 0; p.u2 = 0; p.lit = ins[20:13]; end
`endif
            end
            6'h29: begin p.nop = 0; p.cls = 2; p.s1 = rb; p.u1 = 1; p.d = ra; p.nd = 0; end
            6'h2D: begin p.nop = 0; p.cls = 3; p.s1 = ra; p.u1 = 1; p.s2 = rb; p.u2 = 1; end
            6'h39, 6'h3D: begin p.nop = 0; p.cls = 4; p.s1 = ra; p.u1 = 1; end
            6'h30, 6'h34: begin p.nop = 0; p.cls = 4; p.d = ra; p.nd = 0; end
            6'h1A: begin p.nop = 0; p.cls = 4; p.s1 = rb; p.u1 = 1; p.d = ra; p.nd = 0; end
            default: ;
        endcase
        if (!p.nop) p.ctrl = 5'(1 << p.cls);
        return p;
    endfunction

    function automatic int first_free(input int c);
        for (int t = lo[c]; t < lo[c] + cnt[c]; t++)
            if (!mbusy[t]) return t;
        return 0;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < 16; t++) mbusy[t] = 0;
        mwait = 0;
    endtask

    // One clock cycle of stimulus; the model advances as the DUT would at the edge.
    task automatic step(input bit v, input logic [31:0] ins, input bit rv,
                        input logic [3:0] rt, input bit res, input bit fl);
        pkt_t e;
        bit   exp_ready, xfer;
        int   t;
        @(negedge clk);
        in_valid = v; in_instr = ins; rel_valid = rv; rel_tag = rt;
        br_resolve = res; flush = fl;
        #1;
        e = model_decode(ins);
        t = e.nop ? 0 : first_free(e.cls);
        exp_ready = !mwait && !fl && (e.nop || t != 0);
        last_ready = in_ready;
        check("in_ready", in_ready, exp_ready);
        check("stall", stall, v && !exp_ready);
        xfer = v && exp_ready;
        if (xfer && !e.nop) begin
            e.tag = 4'(t);
            exp_q.push_back(e);
        end
        if (fl) begin
            model_reset();
        end else begin
            if (rv && rt != 0 && rt <= TOTAL) mbusy[rt] = 0;
            if (xfer && !e.nop) mbusy[t] = 1;
            if (xfer && !e.nop && e.cls == 4) mwait = 1;
            else if (mwait && res) mwait = 0;
        end
        @(posedge clk);
        #1;
        in_valid = 0; rel_valid = 0; br_resolve = 0; flush = 0;
    endtask

    task automatic issue(input logic [31:0] ins);
        step(1, ins, 0, 0, 0, 0);
    endtask

    task automatic release_tag(input logic [3:0] rt);
        step(0, 32'h0, 1, rt, 0, 0);
    endtask

    // Direct look at the packet presented in the cycle after the last transfer.
    task automatic peek(input string name, input logic [3:0] tag, input logic [4:0] ctrl,
                        input logic nodest);
        @(negedge clk);
        #2;
        check({name, "_valid"}, iss_valid, 1);
        check({name, "_tag"}, iss_tag, tag);
        check({name, "_ctrl"}, iss_ctrl, ctrl);
        check({name, "_nodest"}, iss_nodest, nodest);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] ra,
                                       input logic [4:0] rb, input logic [4:0] rc);
        return {op, ra, rb, 11'h020, rc};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                pkt_t e;
                e = exp_q.pop_front();
                check("sb_valid", iss_valid, 1);
                check("sb_ctrl", iss_ctrl, e.ctrl);
                check("sb_tag", iss_tag, e.tag);
                check("sb_opcode", iss_opcode, e.op);
                check("sb_src1", iss_src1, e.s1);
                check("sb_src2", iss_src2, e.s2);
                check("sb_dest", iss_dest, e.d);
                check("sb_use", {iss_src1_use, iss_src2_use, iss_nodest}, {e.u1, e.u2, e.nd});
                check("sb_lit", iss_lit, e.lit);
            end else begin
                check("sb_idle", iss_valid, 0);
            end
        end
    end

    initial begin
        logic [31:0] lit_ins;
        logic [5:0]  ops [12];
        cnt = '{N_ADD, N_MULT, N_LD, N_ST, N_BR};
        lo[0] = 1;
        for (int c = 1; c < 5; c++) lo[c] = lo[c-1] + cnt[c-1];
        ops = '{6'h10, 6'h11, 6'h13, 6'h29, 6'h2D, 6'h39, 6'h3D, 6'h30, 6'h34, 6'h1A,
                6'h00, 6'h3F};
        model_reset();

        #22;
        check("rst_iss_valid", iss_valid, 0);
        check("rst_iss_nodest", iss_nodest, 1);
        check("rst_iss_tag", iss_tag, 0);
        check("rst_iss_ctrl", iss_ctrl, 0);
        check("rst_iss_src1", iss_src1, 0);
        @(negedge clk);
        rst_n = 1;

        // Single addq
        issue(32'h40220403);
        peek("addq", 4'd1, 5'b00001, 1'b0);
        check("addq_src1", iss_src1, 1);
        check("addq_src2", iss_src2, 2);
        check("addq_dest", iss_dest, 3);
        release_tag(4'd1);

        // Fill adders, fourth stalls until tag 2 is released
        for (int i = 0; i < 3; i++) issue(mk(6'h10, 5'(i), 5'd7, 5'd9));
        step(1, mk(6'h10, 5'd4, 5'd5, 5'd6), 1, 4'd2, 0, 0);
        check("add4_stalled", last_ready, 0);
        issue(mk(6'h10, 5'd4, 5'd5, 5'd6));
        peek("add4", 4'd2, 5'b00001, 1'b0);
        for (int t = 1; t <= 3; t++) release_tag(4'(t));

        // Branch blocks issue until resolved
        issue(mk(6'h39, 5'd4, 5'd0, 5'd0));
        peek("beq", 4'd11, 5'b10000, 1'b1);
        step(1, 32'h40220403, 0, 0, 0, 0);
        check("br_wait_ready", last_ready, 0);
        step(1, 32'h40220403, 1, 4'd11, 1, 0);
        check("br_resolve_cycle", last_ready, 0);
        issue(32'h40220403);
        check("br_after_resolve", last_ready, 1);
        release_tag(4'd1);

        // Load / store and ignored releases
        issue(mk(6'h29, 5'd5, 5'd6, 5'd0));
        issue(mk(6'h2D, 5'd7, 5'd8, 5'd0));
        release_tag(4'd0);
        release_tag(4'd15);
        issue(mk(6'h29, 5'd1, 5'd2, 5'd0));
        for (int t = 6; t <= 9; t++) release_tag(4'(t));

        // Mult stations full, branch wait, then flush
        issue(mk(6'h13, 5'd1, 5'd2, 5'd3));
        issue(mk(6'h13, 5'd1, 5'd2, 5'd4));
        issue(mk(6'h13, 5'd1, 5'd2, 5'd5));
        issue(mk(6'h30, 5'd26, 5'd0, 5'd0));
        step(1, mk(6'h13, 5'd1, 5'd2, 5'd3), 0, 0, 0, 1);
        issue(mk(6'h13, 5'd1, 5'd2, 5'd3));
        peek("mul_after_flush", 4'd4, 5'b00010, 1'b0);
        release_tag(4'd4);

        // Literal form
        lit_ins = {6'h10, 5'd1, 8'h7F, 1'b1, 7'h00, 5'd3};
        issue(lit_ins);
        peek("lit", 4'd1, 5'b00001, 1'b0);
`ifdef ISSUE_LITERAL_EN
        check("lit_value", iss_lit, 8'h7F);
        check("lit_src2_use", iss_src2_use, 0);
`else
        check("lit_value", iss_lit, 8'h00);
        check("lit_src2_use", iss_src2_use, 1);
`endif
        release_tag(4'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r = $urandom;
            step($urandom_range(0, 3) != 0, {ops[$urandom_range(0, 11)], r[25:0]},
                 $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
        end

        // Asynchronous reset discards a pending packet
        step(0, 32'h0, 0, 0, 0, 1);
        issue(32'h40220403);
        #1;
        rst_n = 0;
        #1;
        check("async_rst_valid", iss_valid, 0);
        check("async_rst_nodest", iss_nodest, 1);
        check("async_rst_tag", iss_tag, 0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        issue(32'h40220403);
        peek("post_rst", 4'd1, 5'b00001, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
